stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_stall_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Hazard-detection and stall control for a five-stage MIPS-style pipeline.
// Detects load-use, branch-operand and HI/LO hazards, tracks the busy window
// of a multi-cycle multiply/divide unit, and counts stalled cycles.
module stall_ctrl #(
    parameter logic [3:0] MULT_LAT = 4'd5,   // mult/multu busy cycles, 1..15
    parameter logic [3:0] DIV_LAT  = 4'd10   // div/divu busy cycles, 1..15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    output logic        PC_En,
    output logic        IF_ID_En,
    output logic        IR_E_Clr,
    output logic        MD_Busy,
    output logic [15:0] Stall_Cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // mult/multu/div/divu occupy funct 0110xx; bit 1 set selects divide.
    function automatic logic is_md_op(input logic [31:0] ir);
        return (ir != 32'd0) && (ir[31:26] == OP_RTYPE) && (ir[5:2] == 4'b0110);
    endfunction

    // Field decode
    logic [5:0] op_d, op_e, op_m;
    logic [4:0] rs_d, rt_d, rt_e, rd_e, rt_m;
    logic [5:0] funct_d, funct_e;

    assign op_d    = IR_D[31:26];
    assign rs_d    = IR_D[25:21];
    assign rt_d    = IR_D[20:16];
    assign funct_d = IR_D[5:0];
    assign op_e    = IR_E[31:26];
    assign rt_e    = IR_E[20:16];
    assign rd_e    = IR_E[15:11];
    assign funct_e = IR_E[5:0];
    assign op_m    = IR_M[31:26];
    assign rt_m    = IR_M[20:16];

    // State and intermediate decisions
    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        md_start, md_busy, hilo_use;
    logic        load_use, branch_haz, hilo_haz, stall;
    logic        d_valid, d_uses_rt, d_is_branch;
    logic [4:0]  e_dest, m_dest;

    // Hazard decode, stall decision and next-state computation
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (avoids latches).
        md_start    = 1'b0;
        md_busy     = 1'b0;
        hilo_use    = 1'b0;
        load_use    = 1'b0;
        branch_haz  = 1'b0;
        hilo_haz    = 1'b0;
        stall       = 1'b0;
        d_valid     = 1'b0;
        d_uses_rt   = 1'b0;
        d_is_branch = 1'b0;
        e_dest      = 5'd0;
        m_dest      = 5'd0;
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;

        // A nop (all-zero word) in any stage is treated as inert.
        d_valid     = (IR_D != 32'd0);
        d_is_branch = d_valid && ((op_d == OP_BEQ) || (op_d == OP_BNE));
        d_uses_rt   = d_valid && ((op_d == OP_RTYPE) || d_is_branch || (op_d == OP_SW));

        // Multiply/divide unit: starts from execute, busy until the counter drains.
        md_start = is_md_op(IR_E);
        md_busy  = md_start || (busy_cnt_q != 4'd0);
        hilo_use = d_valid && (((op_d == OP_RTYPE) && (funct_d[5:2] == 4'b0100)) || is_md_op(IR_D));
        hilo_haz = hilo_use && md_busy;

        // Load-use: decode reads the register a load in execute has not yet fetched.
        load_use = d_valid && (op_e == OP_LW) && (rt_e != 5'd0) &&
                   ((rs_d == rt_e) || (d_uses_rt && (rt_d == rt_e)));

        // Branches compare in decode, so any pending producer in E, or a load in M, blocks them.
        if (IR_E != 32'd0) begin
            unique case (op_e)
                OP_RTYPE:                        e_dest = rd_e;
                OP_ORI, OP_ADDIU, OP_LUI, OP_LW: e_dest = rt_e;
                default:                         e_dest = 5'd0;
            endcase
        end
        if ((IR_M != 32'd0) && (op_m == OP_LW)) begin
            m_dest = rt_m;
        end
        branch_haz = d_is_branch &&
                     (((rs_d != 5'd0) && ((rs_d == e_dest) || (rs_d == m_dest))) ||
                      ((rt_d != 5'd0) && ((rt_d == e_dest) || (rt_d == m_dest))));

        stall = load_use || branch_haz || hilo_haz;

        // Busy counter: a new start always reloads, so a restart replaces the old window.
        if (md_start) begin
            busy_cnt_d = funct_e[1] ? DIV_LAT : MULT_LAT;
        end else if (busy_cnt_q != 4'd0) begin
            busy_cnt_d = busy_cnt_q - 4'd1;
        end

        // Stall counter saturates instead of wrapping.
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers: busy counter and stall counter
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: async reset clears state immediately, so an in-flight busy window is aborted mid-cycle.
        if (!Reset) begin
            busy_cnt_q  <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_En     = !stall;
    assign IF_ID_En  = !stall;
    assign IR_E_Clr  = stall;
    assign MD_Busy   = md_busy;
    assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed testbench for stall_ctrl. Each step drives the three IR inputs,
// pushes the expected outputs to a scoreboard queue, and pops/compares them
// on the falling edge while the combinational outputs are stable.
module tb_stall_ctrl;

    logic        Clk;
    logic        Reset;
    logic [31:0] IR_D, IR_E, IR_M;
    logic        PC_En, IF_ID_En, IR_E_Clr, MD_Busy;
    logic [15:0] Stall_Cnt;

    stall_ctrl #(.MULT_LAT(4'd5), .DIV_LAT(4'd10)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .IR_D      (IR_D),
        .IR_E      (IR_E),
        .IR_M      (IR_M),
        .PC_En     (PC_En),
        .IF_ID_En  (IF_ID_En),
        .IR_E_Clr  (IR_E_Clr),
        .MD_Busy   (MD_Busy),
        .Stall_Cnt (Stall_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction encodings
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW8      = 32'h8C08_0000; // lw   $8,0($0)
    localparam logic [31:0] LW0      = 32'h8C00_0000; // lw   $0,0($0)
    localparam logic [31:0] ADDU8    = 32'h0100_4821; // addu $9,$8,$0
    localparam logic [31:0] ADDU00   = 32'h0000_4821; // addu $9,$0,$0
    localparam logic [31:0] SW8      = 32'hAD28_0000; // sw   $8,0($9)
    localparam logic [31:0] ORI8     = 32'h3408_0001; // ori  $8,$0,1
    localparam logic [31:0] ORI88    = 32'h3508_0001; // ori  $8,$8,1
    localparam logic [31:0] ORI0     = 32'h3500_0001; // ori  $0,$8,1
    localparam logic [31:0] LUI8     = 32'h3C08_0001; // lui  $8,1
    localparam logic [31:0] ADDU_RD8 = 32'h0120_4021; // addu $8,$9,$0
    localparam logic [31:0] ADDU_RD0 = 32'h0108_0021; // addu $0,$8,$8
    localparam logic [31:0] BEQ8     = 32'h1100_0003; // beq  $8,$0
    localparam logic [31:0] BNE08    = 32'h1408_0003; // bne  $0,$8
    localparam logic [31:0] MULT     = 32'h0109_0018; // mult $8,$9
    localparam logic [31:0] DIV      = 32'h0109_001A; // div  $8,$9
    localparam logic [31:0] MFLO     = 32'h0000_5012; // mflo $10
    localparam logic [31:0] MTHI8    = 32'h0100_0011; // mthi $8

    typedef struct {
        string       tag;
        logic        stall;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic compare_outputs();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL sb_underflow: observed 0 entries expected 1");
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, ".pc_en"},    PC_En,     !e.stall);
        check({e.tag, ".if_id_en"}, IF_ID_En,  !e.stall);
        check({e.tag, ".ir_e_clr"}, IR_E_Clr,  e.stall);
        check({e.tag, ".md_busy"},  MD_Busy,   e.busy);
        check({e.tag, ".cnt"},      Stall_Cnt, e.cnt);
    endtask

    // One clock cycle: called just after a rising edge, returns just after the next.
    task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                         input logic stall, input logic busy, input string tag);
        exp_t x;
        IR_D = d;
        IR_E = e;
        IR_M = m;
        x.tag   = tag;
        x.stall = stall;
        x.busy  = busy;
        x.cnt   = exp_cnt;
        sb_q.push_back(x);
        @(negedge Clk);
        compare_outputs();
        @(posedge Clk);
        #1;
        if (stall && Reset && (exp_cnt != 16'hFFFF)) exp_cnt++;
    endtask

    initial begin
        int n_sat;
        Reset = 1'b0;
        IR_D  = NOP;
        IR_E  = NOP;
        IR_M  = NOP;
        repeat (2) @(posedge Clk);
        #1;

        // Held in reset: outputs follow IR inputs, counters stay at zero
        drive(NOP,   NOP,  NOP, 1'b0, 1'b0, "rst_idle");
        drive(NOP,   MULT, NOP, 1'b0, 1'b1, "rst_mult");
        drive(ADDU8, LW8,  NOP, 1'b1, 1'b0, "rst_lu");
        Reset = 1'b1;

        // Load-use hazards
        drive(ADDU8,  LW8, NOP, 1'b1, 1'b0, "lu");
        drive(ADDU8,  NOP, NOP, 1'b0, 1'b0, "lu_rel");
        drive(SW8,    LW8, NOP, 1'b1, 1'b0, "lu_sw");
        drive(ORI8,   LW8, NOP, 1'b0, 1'b0, "lu_ori_rt");
        drive(ADDU00, LW0, NOP, 1'b0, 1'b0, "lu_zero");
        drive(NOP,    LW8, NOP, 1'b0, 1'b0, "nop_d");
        drive(MTHI8,  NOP, NOP, 1'b0, 1'b0, "mthi_idle");

        // Branch hazards
        drive(BEQ8,  ORI88,    NOP,   1'b1, 1'b0, "br_e_ori");
        drive(BEQ8,  NOP,      LW8,   1'b1, 1'b0, "br_m_lw");
        drive(BEQ8,  ADDU_RD8, NOP,   1'b1, 1'b0, "br_e_r");
        drive(BNE08, LUI8,     NOP,   1'b1, 1'b0, "br_bne_lui");
        drive(BEQ8,  ADDU_RD0, NOP,   1'b0, 1'b0, "br_e_r0");
        drive(BEQ8,  ORI0,     NOP,   1'b0, 1'b0, "br_e_ori0");
        drive(BEQ8,  NOP,      LW0,   1'b0, 1'b0, "br_m_lw0");
        drive(BEQ8,  NOP,      ORI88, 1'b0, 1'b0, "br_m_ori");
        drive(BEQ8,  LW8,      NOP,   1'b1, 1'b0, "multi_haz");
        drive(NOP,   NOP,      NOP,   1'b0, 1'b0, "nop_all");

        // Multiply: busy for 1+5 cycles, mflo stalls until busy drops
        drive(MFLO, MULT, NOP, 1'b1, 1'b1, "mul_start");
        for (int i = 0; i < 5; i++) drive(MFLO, NOP, NOP, 1'b1, 1'b1, "mul_busy");
        drive(MFLO, NOP, NOP, 1'b0, 1'b0, "mul_release");

        // Full divide window
        drive(NOP, DIV, NOP, 1'b0, 1'b1, "div_start");
        for (int i = 0; i < 10; i++) drive(NOP, NOP, NOP, 1'b0, 1'b1, "div_busy");
        drive(NOP, NOP, NOP, 1'b0, 1'b0, "div_done");

        // Divide restarted by a multiply on edge 3
        drive(NOP,  DIV,  NOP, 1'b0, 1'b1, "rs_div");
        drive(MULT, NOP,  NOP, 1'b1, 1'b1, "rs_d_md");
        drive(NOP,  NOP,  NOP, 1'b0, 1'b1, "rs_busy");
        drive(NOP,  MULT, NOP, 1'b0, 1'b1, "rs_mult");
        for (int i = 0; i < 5; i++) drive(NOP, NOP, NOP, 1'b0, 1'b1, "rs_tail");
        drive(NOP, NOP, NOP, 1'b0, 1'b0, "rs_done");

        // Saturation: hold a load-use stall until the counter must have pinned
        IR_D  = ADDU8;
        IR_E  = LW8;
        IR_M  = NOP;
        n_sat = 65535 - int'(exp_cnt) + 20;
        for (int i = 0; i < n_sat; i++) begin
            @(posedge Clk);
            if (exp_cnt != 16'hFFFF) exp_cnt++;
        end
        #1;
        drive(ADDU8, LW8,  NOP, 1'b1, 1'b0, "sat");
        drive(ADDU8, LW8,  NOP, 1'b1, 1'b0, "sat_hold");
        drive(NOP,   MULT, NOP, 1'b0, 1'b1, "sat_mult");

        // Asynchronous reset in the middle of a busy window
        IR_E = NOP;
        #2;
        check("pre_rst_busy", MD_Busy, 1'b1);
        check("pre_rst_cnt", Stall_Cnt, 16'hFFFF);
        Reset = 1'b0;
        #1;
        check("async_rst_busy", MD_Busy, 1'b0);
        check("async_rst_cnt", Stall_Cnt, 16'h0000);
        check("async_rst_pc_en", PC_En, 1'b1);
        @(posedge Clk);
        #1;
        Reset   = 1'b1;
        exp_cnt = 16'd0;

        // Normal operation resumes on the first edge after release
        drive(ADDU8, LW8,  NOP, 1'b1, 1'b0, "post_lu");
        drive(NOP,   MULT, NOP, 1'b0, 1'b1, "post_mult");
        drive(NOP,   NOP,  NOP, 1'b0, 1'b1, "post_busy");

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
